// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller.
// Holds the 4-bit FSM state encoding and the opcode and funct constants.
// Also holds the ALUOp and ALUControl constants, plus helpers that
// classify opcode and funct values as supported.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRTypeEx = 4'd6,
        StRTypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctXor = 6'b100110;
    localparam logic [5:0] FunctOr  = 6'b100101;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [2:0] AluCtlAdd = 3'b000;
    localparam logic [2:0] AluCtlSub = 3'b001;
    localparam logic [2:0] AluCtlAnd = 3'b010;
    localparam logic [2:0] AluCtlXor = 3'b011;
    localparam logic [2:0] AluCtlOr  = 3'b100;

    function automatic logic op_is_known(input logic [5:0] op);
        return (op == OpRType) || (op == OpLw) || (op == OpSw) ||
               (op == OpBeq) || (op == OpAddi) || (op == OpJ);
    endfunction

    function automatic logic funct_is_known(input logic [5:0] funct);
        return (funct == FunctAdd) || (funct == FunctSub) || (funct == FunctAnd) ||
               (funct == FunctXor) || (funct == FunctOr);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder for the multicycle controller.
// Ports:
//   alu_op_i        - 2-bit ALUOp from the FSM: add, sub or funct decode.
//   funct_i         - instruction funct field.
//   alu_control_o   - 3-bit ALU operation.
//   funct_illegal_o - high when a funct decode hits an unsupported funct.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o,
    output logic       funct_illegal_o
);

    always_comb begin
        alu_control_o   = AluCtlAdd;
        funct_illegal_o = 1'b0;
        case (alu_op_i)
            AluOpAdd: alu_control_o = AluCtlAdd;
            AluOpSub: alu_control_o = AluCtlSub;
            AluOpFunct: begin
                case (funct_i)
                    FunctAdd: alu_control_o = AluCtlAdd;
                    FunctSub: alu_control_o = AluCtlSub;
                    FunctAnd: alu_control_o = AluCtlAnd;
                    FunctXor: alu_control_o = AluCtlXor;
                    FunctOr:  alu_control_o = AluCtlOr;
                    default: begin
                        alu_control_o   = AluCtlAdd;
                        funct_illegal_o = 1'b1;
                    end
                endcase
            end
            default: alu_control_o = AluCtlAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for a multicycle MIPS-style datapath.
// Ports:
//   clk, reset         - rising-edge clock, synchronous active-high reset.
//   Op, Funct, Zero    - instruction fields and ALU zero status.
//   ALUControl         - ALU operation.
//   ALUSrcA, ALUSrcB   - ALU operand selects.
//   PCSrc              - next-PC select.
//   PCEn, IorD         - PC load enable, memory address select.
//   MemWrite, IRWrite  - memory write and instruction register load.
//   RegDst, MemtoReg   - register-file write address and write data selects.
//   RegWrite           - register-file write enable.
//   IllegalOp          - one-cycle pulse on an unsupported Op or Funct.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic [2:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       IllegalOp
);

    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic       funct_illegal;
    logic       pc_write;
    logic       branch;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (Op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRType:    state_d = StRTypeEx;
                    OpBeq:      state_d = StBeqEx;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJEx;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (Op == OpLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWb;
            StRTypeEx: state_d = StRTypeWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    // Output logic
    always_comb begin
        alu_op        = AluOpAdd;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSrc         = 2'b00;
        IorD          = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b01;
                pc_write     = 1'b1;
            end
            StDecode: begin
                ALUSrcB     = 2'b11;
                illegal_raw = ~op_is_known(Op);
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRd: IorD = 1'b1;
            StMemWb: begin
                reg_write_raw = 1'b1;
                MemtoReg      = 1'b1;
            end
            StMemWr: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
            end
            StRTypeEx: begin
                ALUSrcA     = 1'b1;
                alu_op      = AluOpFunct;
                illegal_raw = funct_illegal;
            end
            StRTypeWb: begin
                // Unsupported funct completes the instruction without a register update.
                reg_write_raw = funct_is_known(Funct);
                RegDst        = 1'b1;
            end
            StBeqEx: begin
                ALUSrcA = 1'b1;
                alu_op  = AluOpSub;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StAddiWb: reg_write_raw = 1'b1;
            StJEx: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i        (alu_op),
        .funct_i         (Funct),
        .alu_control_o   (ALUControl),
        .funct_illegal_o (funct_illegal)
    );

    // Architectural side effects are suppressed while reset is held.
    assign PCEn      = ~reset & (pc_write | (branch & Zero));
    assign MemWrite  = ~reset & mem_write_raw;
    assign IRWrite   = ~reset & ir_write_raw;
    assign RegWrite  = ~reset & reg_write_raw;
    assign IllegalOp = ~reset & illegal_raw;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all encodings are fixed constants from the shared package.
REQ-002 Clock and reset ports: one clock; reset is synchronous and active-high.
  - clk  in  1  rising-edge clock.
  - reset  in  1  synchronous, active-high.
REQ-003 Instruction and status inputs:
  - Op  in  6  opcode field of the instruction register.
  - Funct  in  6  function field of the instruction register.
  - Zero  in  1  ALU equality/zero status.
REQ-004 Datapath control outputs:
  - ALUControl  out  3  ALU operation: 000 add, 001 sub/compare, 010 AND, 011 XOR, 100 OR.
  - ALUSrcA  out  1  0=PC, 1=register A.
  - ALUSrcB  out  2  00=register B, 01=constant 4, 10=sign-extended immediate, 11=immediate<<2.
  - PCSrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target.
REQ-005 Enables and selects:
  - PCEn  out  1  PC load enable.
  - IorD  out  1  memory address select, 0=PC, 1=ALUOut.
  - MemWrite  out  1  memory write enable.
  - IRWrite  out  1  instruction register load.
  - RegDst  out  1  write-register select, 0=rt, 1=rd.
  - MemtoReg  out  1  write-data select, 0=ALUOut, 1=memory data.
  - RegWrite  out  1  register-file write enable.
REQ-006 Status output: IllegalOp  out  1  one-cycle pulse on an unsupported Op or Funct.

Function
REQ-007 Control SHALL be a Moore FSM with twelve states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-008 Transitions:
  - FETCH->DECODE.
  - DECODE by Op: 100011/101011->MEMADR; 000000->RTYPEEX; 000100->BEQEX; 001000->ADDIEX; 000010->JEX; any other Op->FETCH.
  - MEMADR->MEMRD if Op=100011, else MEMWR.
  - MEMRD->MEMWB.
  - RTYPEEX->RTYPEWB.
  - ADDIEX->ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX ->FETCH.
REQ-009 Outputs per state; any output not listed is 0:
  - FETCH: IRWrite=1, ALUSrcB=01, ALUOp add, PCWrite=1.
  - DECODE: ALUSrcB=11, add.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, add.
  - MEMRD: IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWR: IorD=1, MemWrite=1.
  - RTYPEEX: ALUSrcA=1, funct-decoded op.
  - RTYPEWB: RegWrite=1, RegDst=1.
  - BEQEX: ALUSrcA=1, sub, PCSrc=01, Branch=1.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, add.
  - ADDIWB: RegWrite=1.
  - JEX: PCSrc=10, PCWrite=1.
REQ-010 PCEn SHALL equal PCWrite OR (Branch AND Zero), combinationally in the same cycle.
REQ-011 ALUOp is 2 bits: 00=add, 01=sub, 10=funct-decode.
REQ-012 ALU decode for ALUOp=10:
  - Funct 100000->000, 100010->001, 100100->010, 100110->011, 100101->100.
  - Any other Funct->000 with IllegalOp=1.
REQ-013 IllegalOp SHALL pulse in DECODE for an unknown Op, and in RTYPEEX for an unknown Funct.
REQ-014 On unknown Funct: RTYPEWB SHALL still occur with RegWrite forced 0 (no architectural update).
REQ-015 Latency in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal Op 2.
REQ-016 Op and Funct SHALL be sampled only in DECODE, MEMADR, RTYPEEX and RTYPEWB; changes at other times have no effect.

Reset
REQ-017 While reset=1 at a rising clk edge, the state SHALL become FETCH.
REQ-018 While reset=1, PCEn, MemWrite, IRWrite and RegWrite SHALL be forced 0 combinationally, and IllegalOp SHALL be 0.
REQ-019 Reset asserted mid-instruction SHALL abort the instruction; the first cycle after deassertion SHALL be FETCH with normal FETCH outputs.

Structure
REQ-020 The shared package SHALL hold:
  - state encoding (4-bit enumerated);
  - opcode and funct constants;
  - ALUOp and ALUControl constants, matching the ALU's 3-bit encoding.
REQ-021 One sub-module, alu_decoder, SHALL map (ALUOp, Funct) to (ALUControl, funct-illegal flag) combinationally.
REQ-022 The FSM SHALL use one state register plus combinational next-state and output logic.

Verification
REQ-023 lw: reset 2 cycles, Op=100011 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB.
  - IorD=1 in MEMRD.
  - RegWrite=1 and MemtoReg=1 only in MEMWB.
  - Returns to FETCH on cycle 6.
REQ-024 beq: Op=000100 with Zero=1 in BEQEX -> PCEn=1, PCSrc=01, ALUControl=001. Repeat with Zero=0 -> PCEn=0.
REQ-025 R-type: Funct sweep 100000/100010/100100/100110/100101 -> ALUControl 000/001/010/011/100 in RTYPEEX; RegDst=1 and RegWrite=1 in RTYPEWB.
REQ-026 Illegal Op=111111 -> IllegalOp=1 in DECODE, next state FETCH. Funct=000111 -> IllegalOp=1 in RTYPEEX and RegWrite=0 in RTYPEWB.
REQ-027 Reset asserted in MEMWR -> MemWrite=0 in that cycle, and FETCH on the cycle after deassertion.
REQ-028 j: Op=000010 -> PCSrc=10 and PCEn=1 in JEX, 3 cycles total.
